uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter, the transmit end of the core's serial link. The core pushes bytes into a small FIFO. The block serialises them onto `tx`: LSB first, one start bit, STOP_BITS stop bits. Each bit lasts 16 oversample ticks, which matches the host-side 16x oversampling receiver. Bit timing comes from an internal divider, so no external baud clock is needed.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serialiser with an internal
// oversample divider (16 ticks per bit, LSB first, STOP_BITS stop bits).
module uart_tx_fifo #(
    parameter int DEPTH     = 8,
    parameter int DIVISOR   = 1,
    parameter int STOP_BITS = 1
) (
    input  logic                         clk,
    input  logic                         Rst_n,
    input  logic [7:0]                   din,
    input  logic                         wr_en,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ovf,
    input  logic                         clr_ovf,
    output logic                         busy,
    output logic                         tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic          push, pop;
    logic [CW-1:0] count_next;

    logic [DW-1:0] div_cnt;
    logic [3:0]    tick_cnt;
    logic          tick, bit_done;

    logic [7:0]    shift, shift_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic          stop_idx, stop_idx_next;
    logic          tx_next;

    // Pushes are gated by the registered full flag, so a same-cycle pop never frees a slot early.
    assign push       = wr_en && !full;
    assign count_next = count + CW'(push) - CW'(pop);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= din;
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
            if (wr_en && full) ovf <= 1'b1;
            else if (clr_ovf)  ovf <= 1'b0;
        end
    end

    assign tick     = (div_cnt == DW'(DIVISOR - 1));
    assign bit_done = tick && (tick_cnt == 4'd15);

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        shift_next    = shift;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[head];
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_next   = {1'b0, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next    = STOP;
                        stop_idx_next = 1'b0;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame when data is waiting.
                        if (!empty) begin
                            pop        = 1'b1;
                            shift_next = mem[head];
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        stop_idx_next = stop_idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shift    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            shift    <= shift_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
            tx       <= tx_next;
            if (state == IDLE || state_next != state) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_cnt <= tick_cnt + 4'd1;
            end else begin
                div_cnt  <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: default instance with a 16x host receiver model, plus a
// DIVISOR=3 / STOP_BITS=2 instance for slow timing.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din0, din1;
    logic       wr_en0, wr_en1, clr0, clr1;
    logic       full0, empty0, ovf0, busy0, tx0;
    logic       full1, empty1, ovf1, busy1, tx1;
    logic [3:0] count0, count1;

    int checks   = 0;
    int failures = 0;
    int ferr     = 0;
    int ferr_base = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] t2_bytes [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};

    typedef struct {
        int   sel;
        int   k;
        logic tx;
        logic busy;
        int   cnt;
    } vec_t;
    vec_t tbl[$];

    uart_tx_fifo u0 (
        .clk(clk), .Rst_n(rst_n), .din(din0), .wr_en(wr_en0), .full(full0), .empty(empty0),
        .count(count0), .ovf(ovf0), .clr_ovf(clr0), .busy(busy0), .tx(tx0)
    );

    uart_tx_fifo #(.DEPTH(8), .DIVISOR(3), .STOP_BITS(2)) u1 (
        .clk(clk), .Rst_n(rst_n), .din(din1), .wr_en(wr_en1), .full(full1), .empty(empty1),
        .count(count1), .ovf(ovf1), .clr_ovf(clr1), .busy(busy1), .tx(tx1)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Host-side 16x receiver: mid-bit sampling from the start edge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && tx0 === 1'b0) begin
                repeat (8) @(negedge clk);
                if (tx0 === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (16) @(negedge clk);
                        b[i] = tx0;
                    end
                    repeat (16) @(negedge clk);
                    if (tx0 !== 1'b1) ferr++;
                    rx_q.push_back(b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int sel, input int k, input logic t, input logic b, input int c);
        vec_t v;
        v.sel = sel; v.k = k; v.tx = t; v.busy = b; v.cnt = c;
        tbl.push_back(v);
    endtask

    // Driver: push one byte, then walk cycles after the push edge and apply table rows.
    task automatic run_table(input int sel, input logic [7:0] b, input int kmax);
        @(negedge clk);
        if (sel == 0) begin wr_en0 = 1'b1; din0 = b; end
        else          begin wr_en1 = 1'b1; din1 = b; end
        @(posedge clk);
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk);
            wr_en0 = 1'b0;
            wr_en1 = 1'b0;
            foreach (tbl[i]) begin
                if (tbl[i].sel == sel && tbl[i].k == k) begin
                    check($sformatf("tbl%0d_k%0d_tx", i, k), (sel == 0) ? tx0 : tx1, tbl[i].tx);
                    check($sformatf("tbl%0d_k%0d_busy", i, k), (sel == 0) ? busy0 : busy1, tbl[i].busy);
                    if (tbl[i].cnt >= 0)
                        check($sformatf("tbl%0d_k%0d_count", i, k), (sel == 0) ? count0 : count1, tbl[i].cnt);
                end
            end
        end
    endtask

    // Scoreboard: decoded bytes against the expected queue.
    task automatic sb_check(input string name);
        check({name, "_rx_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0)
            check({name, "_rx_byte"}, rx_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        int k;
        int peak;
        int lows;
        int busys;

        rst_n = 1'b0;
        din0 = '0; din1 = '0; wr_en0 = 1'b0; wr_en1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;

        // 0x55 on the default instance: start k=1..16, bit b at k=17+16b..32+16b, stop k=145..160
        add_vec(0,   0, 1'b1, 1'b0,  1);
        add_vec(0,   1, 1'b0, 1'b1,  0);
        add_vec(0,  16, 1'b0, 1'b1, -1);
        add_vec(0,  17, 1'b1, 1'b1, -1);
        add_vec(0,  32, 1'b1, 1'b1, -1);
        add_vec(0,  33, 1'b0, 1'b1, -1);
        add_vec(0,  48, 1'b0, 1'b1, -1);
        add_vec(0,  49, 1'b1, 1'b1, -1);
        add_vec(0,  65, 1'b0, 1'b1, -1);
        add_vec(0,  81, 1'b1, 1'b1, -1);
        add_vec(0,  97, 1'b0, 1'b1, -1);
        add_vec(0, 113, 1'b1, 1'b1, -1);
        add_vec(0, 129, 1'b0, 1'b1, -1);
        add_vec(0, 144, 1'b0, 1'b1, -1);
        add_vec(0, 145, 1'b1, 1'b1, -1);
        add_vec(0, 160, 1'b1, 1'b1, -1);
        add_vec(0, 161, 1'b1, 1'b0,  0);
        // 0x80 on the slow instance: 48 clk bits, bit7 at k=385..432, stop k=433..528
        add_vec(1,   0, 1'b1, 1'b0,  1);
        add_vec(1,   1, 1'b0, 1'b1,  0);
        add_vec(1,  48, 1'b0, 1'b1, -1);
        add_vec(1,  49, 1'b0, 1'b1, -1);
        add_vec(1, 384, 1'b0, 1'b1, -1);
        add_vec(1, 385, 1'b1, 1'b1, -1);
        add_vec(1, 432, 1'b1, 1'b1, -1);
        add_vec(1, 433, 1'b1, 1'b1, -1);
        add_vec(1, 528, 1'b1, 1'b1, -1);
        add_vec(1, 529, 1'b1, 1'b0,  0);

        repeat (2) @(negedge clk);
        check("rst_tx", tx0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_full", full0, 1'b0);
        check("rst_empty", empty0, 1'b1);
        check("rst_count", count0, 0);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_tx_slow", tx1, 1'b1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte
        exp_q.push_back(8'h55);
        run_table(0, 8'h55, 170);
        sb_check("t1");

        // Back-to-back frames
        @(negedge clk);
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            wr_en0 = 1'b1;
            din0   = t2_bytes[i];
            exp_q.push_back(t2_bytes[i]);
            @(posedge clk);
            @(negedge clk);
            if (int'(count0) > peak) peak = int'(count0);
        end
        wr_en0 = 1'b0;
        k = 3;
        while (busy0 && k < 1000) begin
            @(negedge clk);
            k++;
            if (int'(count0) > peak) peak = int'(count0);
        end
        check("t2_end_cycle", k, 641);
        check("t2_count_peak", peak, 3);
        sb_check("t2");

        // Overflow
        for (int i = 0; i < 10; i++) begin
            wr_en0 = 1'b1;
            din0   = 8'(i + 1);
            if (i < 9) exp_q.push_back(8'(i + 1));
            @(posedge clk);
            @(negedge clk);
            if (i == 7) check("t3_full_k7", full0, 1'b0);
            if (i == 8) begin
                check("t3_full_k8", full0, 1'b1);
                check("t3_ovf_k8", ovf0, 1'b0);
            end
            if (i == 9) begin
                check("t3_ovf_k9", ovf0, 1'b1);
                check("t3_count_k9", count0, 8);
            end
        end
        wr_en0 = 1'b0;
        k = 9;
        while (busy0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("t3_end_cycle", k, 1441);
        sb_check("t3");
        check("rx_framing", ferr - ferr_base, 0);
        check("t3_ovf_sticky", ovf0, 1'b1);
        clr0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr0 = 1'b0;
        check("t3_ovf_cleared", ovf0, 1'b0);

        // Set/clear collision
        for (int i = 0; i < 9; i++) begin
            wr_en0 = 1'b1;
            din0   = 8'(8'h40 + i);
            @(posedge clk);
            @(negedge clk);
        end
        check("t6_full", full0, 1'b1);
        wr_en0 = 1'b1;
        din0   = 8'hEE;
        clr0   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_en0 = 1'b0;
        clr0   = 1'b0;
        check("t6_ovf_set_wins", ovf0, 1'b1);
        check("t6_count", count0, 8);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ovf", ovf0, 1'b0);
        check("t6_rst_full", full0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);

        // Reset mid-frame
        for (int i = 0; i < 3; i++) begin
            wr_en0 = 1'b1;
            din0   = 8'(8'h11 * (i + 1));
            @(posedge clk);
            @(negedge clk);
        end
        wr_en0 = 1'b0;
        k = 2;
        while (k < 70) begin
            @(negedge clk);
            k++;
        end
        check("t4_bit3_tx", tx0, 1'b0);
        check("t4_queued", count0, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_tx", tx0, 1'b1);
        check("t4_async_busy", busy0, 1'b0);
        check("t4_async_count", count0, 0);
        check("t4_async_empty", empty0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        busys = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lows++;
            if (busy0 !== 1'b0) busys++;
        end
        check("t4_idle_tx_low_cycles", lows, 0);
        check("t4_idle_busy_cycles", busys, 0);
        rx_q.delete();
        exp_q.delete();
        ferr_base = ferr;

        // Slow timing
        run_table(1, 8'h80, 540);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
